avl_arbiter_2m: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter.
- Shares a single memory slave (e.g. avl_slave_mem_2) between the CPU bus interface (harvard_to_avalon) on port m0 and a second master (debug loader / DMA) on port m1.
- Grants are round-robin. A grant is held for exactly one complete transfer.
- A watchdog aborts transfers on a hung slave and raises a sticky error flag.

---
 rtl/avl_arb_pkg.sv | 13 +
 rtl/avl_arb_watchdog.sv | 30 +++
 rtl/avl_arbiter_2m.sv | 165 ++++++++++++++++
 tb/tb_avl_arbiter_2m.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;

  localparam logic [31:0] BUS_ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/avl_arb_watchdog.sv
// Counts consecutive stalled cycles of the current grant; flags the edge
// on which the count reaches TIMEOUT_CYCLES-1.
module avl_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wd_cnt_r;

  assign expired = inc && (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 2));

  // Stall counter: cleared whenever no grant is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_r <= '0;
    end else if (clear) begin
      wd_cnt_r <= '0;
    end else if (inc) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/avl_arbiter_2m.sv
// Round-robin arbiter sharing one Avalon-MM slave between two masters,
// one complete transfer per grant, with a hung-slave watchdog.
module avl_arbiter_2m
  import avl_arb_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0] BUS_ERR_DATA   = DATA_W'(BUS_ERR_DATA_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic                  m0_read,
  input  logic                  m0_write,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic                  m1_read,
  input  logic                  m1_write,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_W-1:0]     s_address,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [DATA_W-1:0]     s_writedata,
  output logic                  s_read,
  output logic                  s_write,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_waitrequest,
  output logic                  timeout_err
);

  arb_state_e state_r, state_nxt_s;
  logic       last_grant_r, last_grant_nxt_s;
  logic       timeout_err_r, timeout_err_nxt_s;
  logic       req0_s, req1_s, gnt_s, wd_inc_s, wd_expired_s;

  assign req0_s      = m0_read | m0_write;
  assign req1_s      = m1_read | m1_write;
  assign gnt_s       = (state_r == ST_GNT0) || (state_r == ST_GNT1);
  assign wd_inc_s    = s_waitrequest && (((state_r == ST_GNT0) && req0_s) ||
                                         ((state_r == ST_GNT1) && req1_s));
  assign timeout_err = timeout_err_r;

  avl_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!gnt_s),
    .inc     (wd_inc_s),
    .expired (wd_expired_s)
  );

  // Next-state logic; last_grant is taken on abort entry so ABORT knows its master.
  always_comb begin
    state_nxt_s       = state_r;
    last_grant_nxt_s  = last_grant_r;
    timeout_err_nxt_s = timeout_err_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          state_nxt_s = last_grant_r ? ST_GNT0 : ST_GNT1;
        end else if (req0_s) begin
          state_nxt_s = ST_GNT0;
        end else if (req1_s) begin
          state_nxt_s = ST_GNT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (!req0_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!s_waitrequest) begin
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = 1'b0;
        end else if (wd_expired_s) begin
          state_nxt_s       = ST_ABORT;
          last_grant_nxt_s  = 1'b0;
          timeout_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_GNT0;
        end
      end
      ST_GNT1: begin
        if (!req1_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!s_waitrequest) begin
          state_nxt_s      = ST_IDLE;
          last_grant_nxt_s = 1'b1;
        end else if (wd_expired_s) begin
          state_nxt_s       = ST_ABORT;
          last_grant_nxt_s  = 1'b1;
          timeout_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_GNT1;
        end
      end
      ST_ABORT: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State registers; reset biases the first tie toward m0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= 1'b1;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      last_grant_r  <= last_grant_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  // Bus muxing: decoded from state only, so strobes drop the moment reset asserts.
  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    case (state_r)
      ST_GNT0: begin
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      ST_GNT1: begin
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      ST_ABORT: begin
        if (last_grant_r == 1'b0) begin
          m0_waitrequest = 1'b0;
          m0_readdata    = BUS_ERR_DATA;
        end else begin
          m1_waitrequest = 1'b0;
          m1_readdata    = BUS_ERR_DATA;
        end
      end
      default: begin
        s_read = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_avl_arbiter_2m.sv
// Scoreboard bench for avl_arbiter_2m with a 1-wait-state memory slave model.
module tb_avl_arbiter_2m;

  localparam int TO = 8;

  logic        clk, rst;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic [3:0]  m0_byteenable;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic [3:0]  m1_byteenable;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic        s_read, s_write, s_waitrequest, timeout_err;

  logic        hang, mem_init, served;
  logic [31:0] mem [0:63];

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   order_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  avl_arbiter_2m #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .BUS_ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_write(m0_write), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: one wait state per access; hang holds waitrequest high.
  assign s_waitrequest = hang | ((s_read | s_write) & ~served);
  assign s_readdata    = mem[s_address[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      served <= 1'b0;
    end else begin
      served <= (s_read | s_write) & ~served & ~hang;
      if (s_write && !s_waitrequest)
        for (int b = 0; b < 4; b++)
          if (s_byteenable[b]) mem[s_address[7:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic complete(input int m, input logic [31:0] rd);
    exp_t e;
    int   o;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      n_chk++;
      $display("FAIL unexpected_completion m%0d: readdata %h, nothing outstanding", m, rd);
    end else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (e.chk) check($sformatf("m%0d_readdata", m), rd, e.data);
    end
    if (order_q.size() > 0) begin
      o = order_q.pop_front();
      check("grant_order", 32'(m), 32'(o));
    end
  endtask

  // Monitor: any falling waitrequest is a completed transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (!m0_waitrequest) complete(0, m0_readdata);
      if (!m1_waitrequest) complete(1, m1_readdata);
    end
  end

  task automatic clear_master(input int m);
    if (m == 0) begin
      m0_address = '0; m0_byteenable = '0; m0_writedata = '0; m0_read = 1'b0; m0_write = 1'b0;
    end else begin
      m1_address = '0; m1_byteenable = '0; m1_writedata = '0; m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  // Called just after a posedge; returns just after the posedge that ends the transfer.
  task automatic xfer(input int m, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input bit chk,
                      input logic [31:0] exp_rd);
    exp_t e;
    bit   done;
    e.chk  = chk;
    e.data = exp_rd;
    done   = 1'b0;
    if (m == 0) begin
      exp_q0.push_back(e);
      m0_address = addr; m0_byteenable = be; m0_writedata = wd; m0_read = rd; m0_write = wr;
    end else begin
      exp_q1.push_back(e);
      m1_address = addr; m1_byteenable = be; m1_writedata = wd; m1_read = rd; m1_write = wr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL xfer_timeout m%0d: waitrequest still 1 after 40 cycles, required 0", m);
    end
    @(posedge clk);
    #1;
    clear_master(m);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int stall;
    bit seen;
    rst = 1'b0; mem_init = 1'b1; hang = 1'b0;
    clear_master(0);
    clear_master(1);
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b1;

    // Reset state
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_s_address", s_address, 0);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_m0_rdata", m0_readdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;

    // Single master read; arbitration cycle has no strobe
    fork
      xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 32'h0, 1'b1, 32'h1000_0000);
      begin
        @(negedge clk);
        check("arb_cycle_s_read", s_read, 0);
        @(negedge clk);
        check("gnt0_s_read", s_read, 1);
        check("gnt0_m1_wait", m1_waitrequest, 1);
      end
    join

    // Simultaneous requests after reset: m0 first
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    order_q.push_back(0); order_q.push_back(1);
    fork
      xfer(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h1000_0000);
      xfer(1, 1'b0, 1'b1, 32'h4, 4'hF, 32'h1122_3344, 1'b0, 32'h0);
    join
    xfer(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h1122_3344);

    // Byte-lane write through m1 (leaves last_grant = m1)
    xfer(1, 1'b0, 1'b1, 32'hAC, 4'b0100, 32'hDDCC_BBAA, 1'b0, 32'h0);

    // Sustained contention: strict alternation starting with m0
    for (int k = 0; k < 4; k++) begin
      order_q.push_back(0);
      order_q.push_back(1);
    end
    fork
      for (int k = 0; k < 4; k++)
        xfer(0, 1'b1, 1'b0, 32'h10 + 32'(4*k), 4'hF, 32'h0, 1'b1, 32'h1000_0004 + 32'(k));
      for (int j = 0; j < 4; j++)
        xfer(1, 1'b1, 1'b0, 32'h20 + 32'(4*j), 4'hF, 32'h0, 1'b1, 32'h1000_0008 + 32'(j));
    join
    xfer(0, 1'b1, 1'b0, 32'hAC, 4'hF, 32'h0, 1'b1, 32'h10CC_002B);

    // Hung slave: abort on cycle 8 of the grant
    hang = 1'b1;
    stall = 0;
    seen = 1'b0;
    fork
      xfer(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);
      begin
        for (int c = 0; c < 30 && !seen; c++) begin
          @(negedge clk);
          if (!m0_waitrequest) begin
            seen = 1'b1;
            check("abort_timeout_err", timeout_err, 1);
            check("abort_s_read", s_read, 0);
          end else if (s_read) begin
            stall++;
          end
        end
        check("abort_stall_cycles", 32'(stall), 32'd7);
      end
    join
    hang = 1'b0;
    xfer(1, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0, 1'b1, 32'h1000_0009);
    check("timeout_err_sticky", timeout_err, 1);

    // Async reset in GNT1 while the slave stalls
    hang = 1'b1;
    m1_address = 32'h20; m1_byteenable = 4'hF; m1_read = 1'b1;
    @(negedge clk);
    check("gnt1_arb_s_read", s_read, 0);
    @(negedge clk);
    check("gnt1_s_read", s_read, 1);
    check("gnt1_m0_wait", m0_waitrequest, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_rst_s_read", s_read, 0);
    check("async_rst_s_write", s_write, 0);
    check("async_rst_m0_wait", m0_waitrequest, 1);
    check("async_rst_m1_wait", m1_waitrequest, 1);
    check("async_rst_timeout_err", timeout_err, 0);
    clear_master(1);
    hang = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    order_q.push_back(0); order_q.push_back(1);
    fork
      xfer(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b1, 32'h1122_3344);
      xfer(1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 32'h1000_0000);
    join

    repeat (3) @(negedge clk);
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("order_q_drained", 32'(order_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
